mmio_io_ctrl: RTL and testbench
===============================

// Module: mmio_io_ctrl
// PURPOSE
// - Parametrised memory-mapped I/O controller between the pipelined core's data-memory port and the board pins.
// - Generalises fixed switch/LED decode to NUM_SW_CH switch words and NUM_LED_CH LED words.
// - Adds switch synchronisation + debounce and a CPU-writable, time-multiplexed 4-digit 7-segment display.
// - Sits on the DM bus: decodes DM_addr, returns I/O data or passes memory read data through.
// PARAMETERS
// - N          64        bus data/address width
// - NUM_SW_CH  1         number of 16-bit switch input words (1..16)
// - NUM_LED_CH 1         number of 16-bit LED output words (1..16)
// - BASE_ADDR  64'h8000  base of I/O window (8-byte aligned)
// - DEB_CYCLES 4         consecutive stable cycles needed to accept a switch change (>=1)
// - SCAN_DIV   14        display digit period = 2**SCAN_DIV i_mclk cycles
// PORTS
// - i_mclk     in   1               clock, all logic on rising edge
// - i_reset    in   1               synchronous reset, active-high
// - i_addr     in   N               DM byte address
// - i_wdata    in   N               DM write data
// - i_we       in   1               DM write enable
// - i_re       in   1               DM read enable
// - i_mem_rdata in  N               read data from dmem
// - o_rdata    out  N               read data to datapath (I/O or pass-through)
// - o_hit      out  1               i_addr matches a mapped I/O register
// - i_sw       in   16*NUM_SW_CH    raw asynchronous switch pins
// - o_led      out  16*NUM_LED_CH   LED outputs, registered
// - o_seg      out  8               {dp,g,f,e,d,c,b,a}, active-low
// - o_dig_en   out  4               digit enables, active-low one-hot
// - o_irq      out  1               only with MMIO_SW_IRQ_EN
// BEHAVIOUR
// - Map (offsets from BASE_ADDR): SW k at 0x000+8k (RO); LED k at 0x100+8k (RW); DISP 0x200 (RW, 16 bits, digit0=[3:0]);
//   BLANK 0x208 (RW, 4 bits, 1=digit off); IRQ_STAT 0x210 (macro only). Any other address: o_hit=0.
// - Reads combinational: o_hit=1 -> o_rdata = register zero-extended to N; o_hit=0 -> o_rdata = i_mem_rdata. i_re does not gate o_rdata.
// - Writes: i_we & o_hit to RW register -> update on next rising edge, low bits of i_wdata; same-cycle read returns old value.
// - Writes to SW addresses ignored. i_we & i_re together both act. o_hit=0 writes touch nothing here.
// - Reset values: o_led=0, DISP=0, BLANK=4'hF, debounced SW=0, candidate=0, deb count=0, digit idx=0,
//   o_dig_en=4'b1110, o_seg=8'hFF, IRQ_STAT=0, o_irq=0.
// - Switch path per channel (16-bit word is one unit): 2-flop synchroniser -> sync2.
//   sync2!=cand: cand<=sync2, cnt<=0. Else cnt==DEB_CYCLES-1: stable<=cand. Else cnt<=cnt+1.
//   Change held from before edge 1 is readable after edge DEB_CYCLES+3; a glitch shorter than DEB_CYCLES cycles never reaches stable.
// - Display: free-running SCAN_DIV-bit counter; when all-ones, idx<=idx+1 (3 wraps to 0).
//   o_dig_en = ~(4'b1<<idx) registered; o_seg = hex decode of DISP nibble idx (0-F, dp=1), or 8'hFF if BLANK[idx].
//   o_seg/o_dig_en registered together; DISP/BLANK writes visible at next scan-register update.
// - Reset mid-operation: all state returns to reset values on the edge; no partial debounce or scan retained.
// CONFIGURATION
// - MMIO_SW_IRQ_EN defined: IRQ_STAT[NUM_SW_CH-1:0] sticky, bit k set on edge where stable SW k changes;
//   write 1s to IRQ_STAT clear bits; set wins over clear in same cycle; o_irq = |IRQ_STAT, registered.
// - MMIO_SW_IRQ_EN undefined: no o_irq port, no IRQ_STAT, offset 0x210 gives o_hit=0 (pass-through).
// TESTING
// - Reset, read 0x8000 with i_mem_rdata=64'hDEAD -> o_rdata=0, o_hit=1; read 0x7FF8 -> o_rdata=64'hDEAD, o_hit=0.
// - DEB_CYCLES=4: i_sw 0->16'hA5A5 held -> SW read 0 through edge 6, 64'hA5A5 after edge 7; 3-cycle pulse -> never seen.
// - Write 64'h1234_BEEF to 0x8100 -> o_led=16'hBEEF next edge; same-cycle read returns 0; write to 0x8000 -> no effect.
// - SCAN_DIV=2, DISP=16'h4A21, BLANK=4'b0100 -> digits cycle every 4 clks: seg(1),seg(2),8'hFF,seg(4); dig_en 1110,1101,1011,0111.
// - NUM_SW_CH=2: i_sw[31:16]=16'h0F0F -> 0x8008 reads 64'h0F0F, 0x8000 unchanged.
// - MMIO_SW_IRQ_EN: SW0 change -> o_irq=1; write 1 to 0x8210 -> o_irq=0; clear coinciding with new change -> bit stays 1.

Source files
------------

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O on the data-memory bus: debounced switches, LED words and a scanned 4-digit 7-segment display.
// Define MMIO_SW_IRQ_EN to add the sticky switch-change status register (offset 0x210) and the o_irq output.
module mmio_io_ctrl #(
    parameter int             N          = 64,
    parameter int             NUM_SW_CH  = 1,
    parameter int             NUM_LED_CH = 1,
    parameter logic [N-1:0]   BASE_ADDR  = 'h8000,
    parameter int             DEB_CYCLES = 4,
    parameter int             SCAN_DIV   = 14
) (
    input  logic                    i_mclk,
    input  logic                    i_reset,
    input  logic [N-1:0]            i_addr,
    input  logic [N-1:0]            i_wdata,
    input  logic                    i_we,
    input  logic                    i_re,
    input  logic [N-1:0]            i_mem_rdata,
    output logic [N-1:0]            o_rdata,
    output logic                    o_hit,
    input  logic [16*NUM_SW_CH-1:0] i_sw,
    output logic [16*NUM_LED_CH-1:0] o_led,
    output logic [7:0]              o_seg,
    output logic [3:0]              o_dig_en
`ifdef MMIO_SW_IRQ_EN
    ,
    output logic                    o_irq
`endif
);

    localparam int            CW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [N-1:0]                  off;
    logic                          in_win;
    logic [NUM_SW_CH-1:0]          sw_sel;
    logic [NUM_LED_CH-1:0]         led_sel;
    logic                          disp_sel;
    logic                          blank_sel;
    logic [N-1:0]                  io_data;

    logic [NUM_SW_CH-1:0][15:0]    sw_sync1;
    logic [NUM_SW_CH-1:0][15:0]    sw_sync2;
    logic [NUM_SW_CH-1:0][15:0]    sw_cand;
    logic [NUM_SW_CH-1:0][15:0]    sw_stable;
    logic [NUM_SW_CH-1:0][CW-1:0]  sw_cnt;

    logic [NUM_LED_CH-1:0][15:0]   led_q;
    logic [15:0]                   disp;
    logic [3:0]                    blank;
    logic [SCAN_DIV-1:0]           scan_cnt;
    logic [1:0]                    idx;
    logic [3:0]                    nibble;

    logic                          unused_bits;

    assign unused_bits = ^{i_re, i_wdata[N-1:16]};

    // Offset is only meaningful at or above the base; below it the subtraction wraps.
    assign off       = i_addr - BASE_ADDR;
    assign in_win    = (i_addr >= BASE_ADDR);
    assign disp_sel  = in_win && (off == N'(512));
    assign blank_sel = in_win && (off == N'(520));

    always_comb begin
        sw_sel  = '0;
        led_sel = '0;
        for (int k = 0; k < NUM_SW_CH; k++) begin
            sw_sel[k] = in_win && (off == N'(8 * k));
        end
        for (int k = 0; k < NUM_LED_CH; k++) begin
            led_sel[k] = in_win && (off == N'(256 + 8 * k));
        end
    end

`ifdef MMIO_SW_IRQ_EN
    logic                 irq_sel;
    logic [NUM_SW_CH-1:0] irq_stat;
    logic [NUM_SW_CH-1:0] sw_chg;
    logic [NUM_SW_CH-1:0] irq_clr;

    assign irq_sel = in_win && (off == N'(528));
    assign irq_clr = (i_we && irq_sel) ? i_wdata[NUM_SW_CH-1:0] : '0;

    // A channel changes on exactly the edge where its candidate is accepted as new stable value.
    always_comb begin
        sw_chg = '0;
        for (int k = 0; k < NUM_SW_CH; k++) begin
            sw_chg[k] = (sw_sync2[k] == sw_cand[k]) && (sw_cnt[k] == CNT_MAX)
                        && (sw_cand[k] != sw_stable[k]);
        end
    end

    always_ff @(posedge i_mclk) begin
        if (i_reset) begin
            irq_stat <= '0;
            o_irq    <= 1'b0;
        end else begin
            irq_stat <= (irq_stat & ~irq_clr) | sw_chg;
            o_irq    <= |irq_stat;
        end
    end
`endif

    always_comb begin
        o_hit   = 1'b0;
        io_data = '0;
        for (int k = 0; k < NUM_SW_CH; k++) begin
            if (sw_sel[k]) begin
                o_hit   = 1'b1;
                io_data = N'(sw_stable[k]);
            end
        end
        for (int k = 0; k < NUM_LED_CH; k++) begin
            if (led_sel[k]) begin
                o_hit   = 1'b1;
                io_data = N'(led_q[k]);
            end
        end
        if (disp_sel) begin
            o_hit   = 1'b1;
            io_data = N'(disp);
        end
        if (blank_sel) begin
            o_hit   = 1'b1;
            io_data = N'(blank);
        end
`ifdef MMIO_SW_IRQ_EN
        if (irq_sel) begin
            o_hit   = 1'b1;
            io_data = N'(irq_stat);
        end
`endif
    end

    assign o_rdata = o_hit ? io_data : i_mem_rdata;

    always_ff @(posedge i_mclk) begin
        if (i_reset) begin
            led_q <= '0;
            disp  <= '0;
            blank <= 4'hF;
        end else if (i_we) begin
            for (int k = 0; k < NUM_LED_CH; k++) begin
                if (led_sel[k]) led_q[k] <= i_wdata[15:0];
            end
            if (disp_sel)  disp  <= i_wdata[15:0];
            if (blank_sel) blank <= i_wdata[3:0];
        end
    end

    assign o_led = led_q;

    // Each 16-bit word debounces as a unit: any bit moving restarts the stability count.
    always_ff @(posedge i_mclk) begin
        if (i_reset) begin
            sw_sync1  <= '0;
            sw_sync2  <= '0;
            sw_cand   <= '0;
            sw_stable <= '0;
            sw_cnt    <= '0;
        end else begin
            sw_sync1 <= i_sw;
            sw_sync2 <= sw_sync1;
            for (int k = 0; k < NUM_SW_CH; k++) begin
                if (sw_sync2[k] != sw_cand[k]) begin
                    sw_cand[k] <= sw_sync2[k];
                    sw_cnt[k]  <= '0;
                end else if (sw_cnt[k] == CNT_MAX) begin
                    sw_stable[k] <= sw_cand[k];
                end else begin
                    sw_cnt[k] <= sw_cnt[k] + 1'b1;
                end
            end
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign nibble = disp[{idx, 2'b00} +: 4];

    // Segment and enable registers track the current digit one clock behind the index.
    always_ff @(posedge i_mclk) begin
        if (i_reset) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
            o_dig_en <= 4'b1110;
            o_seg    <= 8'hFF;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
            if (&scan_cnt) idx <= idx + 2'd1;
            o_dig_en <= ~(4'b0001 << idx);
            o_seg    <= blank[idx] ? 8'hFF : {1'b1, hex7(nibble)};
        end
    end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl with two switch/LED channels, 4-cycle debounce and a 4-clock digit period.
module tb_mmio_io_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        we;
    logic        re;
    logic [63:0] mem_rdata;
    logic [63:0] rdata;
    logic        hit;
    logic [31:0] sw;
    logic [31:0] led;
    logic [7:0]  seg;
    logic [3:0]  dig_en;
`ifdef MMIO_SW_IRQ_EN
    logic        irq;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int n;

    logic [3:0] exp_dig [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] exp_seg [4] = '{8'hF9, 8'hA4, 8'hFF, 8'h99};

    mmio_io_ctrl #(
        .N(64), .NUM_SW_CH(2), .NUM_LED_CH(2), .BASE_ADDR(64'h8000),
        .DEB_CYCLES(4), .SCAN_DIV(2)
    ) dut (
        .i_mclk(clk),
        .i_reset(rst),
        .i_addr(addr),
        .i_wdata(wdata),
        .i_we(we),
        .i_re(re),
        .i_mem_rdata(mem_rdata),
        .o_rdata(rdata),
        .o_hit(hit),
        .i_sw(sw),
        .o_led(led),
        .o_seg(seg),
        .o_dig_en(dig_en)
`ifdef MMIO_SW_IRQ_EN
        ,
        .o_irq(irq)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required $finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [63:0] a);
        addr = a;
        #1;
    endtask

    initial begin
        rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b1;
        mem_rdata = 64'hDEAD; sw = '0;
        tick;
        tick;
        check("rst_led", led, 0);
        check("rst_dig_en", dig_en, 4'b1110);
        check("rst_seg", seg, 8'hFF);
`ifdef MMIO_SW_IRQ_EN
        check("rst_irq", irq, 0);
`endif

        rst = 1'b0;
        sw[15:0] = 16'hA5A5;
        rd(64'h8000);
        check("rd_sw0_rst", rdata, 0);
        check("hit_sw0", hit, 1);
        rd(64'h7FF8);
        check("rd_below", rdata, 64'hDEAD);
        check("hit_below", hit, 0);
        rd(64'h8208);
        check("rst_blank", rdata, 64'hF);
        rd(64'h8000);

        for (int e = 1; e <= 6; e++) tick;
        check("deb_edge6", rdata, 0);
        tick;
        check("deb_edge7", rdata, 64'hA5A5);

        sw[15:0] = 16'h00FF;
        repeat (3) tick;
        sw[15:0] = 16'hA5A5;
        repeat (3) tick;
        check("glitch_mid", rdata, 64'hA5A5);
        repeat (7) tick;
        check("glitch_end", rdata, 64'hA5A5);

        sw[31:16] = 16'h0F0F;
        repeat (7) tick;
        rd(64'h8008);
        check("sw1", rdata, 64'h0F0F);
        rd(64'h8000);
        check("sw0_after_sw1", rdata, 64'hA5A5);
        rd(64'h8010);
        check("sw2_unmapped", rdata, 64'hDEAD);

        addr = 64'h8100; wdata = 64'h1234_BEEF; we = 1'b1;
        #1;
        check("led0_same_cycle", rdata, 0);
        check("led_before", led, 0);
        tick;
        we = 1'b0;
        #1;
        check("led_after", led, 32'h0000_BEEF);
        check("led0_read", rdata, 64'hBEEF);
        addr = 64'h8108; wdata = 64'hFFFF_5555; we = 1'b1;
        tick;
        addr = 64'h8000; wdata = 64'hFFFF;
        tick;
        addr = 64'h7FF8;
        tick;
        addr = 64'h8110;
        tick;
        we = 1'b0;
        check("led_both", led, 32'h5555_BEEF);
        rd(64'h8000);
        check("sw_write_ignored", rdata, 64'hA5A5);

        addr = 64'h8200; wdata = 64'h4A21; we = 1'b1;
        tick;
        addr = 64'h8208; wdata = 64'h4;
        tick;
        we = 1'b0;
        rd(64'h8200);
        check("disp_read", rdata, 64'h4A21);
        rd(64'h8208);
        check("blank_read", rdata, 64'h4);

        tick;
        n = 0;
        while ((cyc % 4) != 2 && n < 8) begin
            tick;
            n++;
        end
        if (n >= 8) begin
            miscompares++;
            $display("FAIL scan_align: observed no phase-2 cycle required one within 8");
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("dig_en_idx%0d", (cyc / 4) % 4), dig_en, exp_dig[(cyc / 4) % 4]);
            check($sformatf("seg_idx%0d", (cyc / 4) % 4), seg, exp_seg[(cyc / 4) % 4]);
            repeat (4) tick;
        end

        sw[15:0] = 16'h3C3C;
        repeat (3) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        rd(64'h8000);
        check("mid_rst_sw0", rdata, 0);
        check("mid_rst_led", led, 0);
        check("mid_rst_dig_en", dig_en, 4'b1110);
        check("mid_rst_seg", seg, 8'hFF);
        rd(64'h8200);
        check("mid_rst_disp", rdata, 0);
        rd(64'h8000);
        for (int e = 1; e <= 6; e++) tick;
        check("mid_rst_edge6", rdata, 0);
        tick;
        check("mid_rst_edge7", rdata, 64'h3C3C);
        rd(64'h8008);
        check("mid_rst_sw1", rdata, 64'h0F0F);

`ifdef MMIO_SW_IRQ_EN
        addr = 64'h8210; wdata = 64'h3; we = 1'b1;
        tick;
        we = 1'b0;
        tick;
        check("irq_cleared", irq, 0);
        check("irq_stat_cleared", rdata, 0);
        sw[15:0] = 16'h1111;
        repeat (8) tick;
        check("irq_set", irq, 1);
        check("irq_stat_set", rdata, 64'h1);
        wdata = 64'h1; we = 1'b1;
        tick;
        we = 1'b0;
        tick;
        check("irq_clear2", irq, 0);
        sw[15:0] = 16'h2222;
        repeat (6) tick;
        wdata = 64'h1; we = 1'b1;
        tick;
        we = 1'b0;
        #1;
        check("irq_set_wins", rdata, 64'h1);
`else
        rd(64'h8210);
        check("irq_addr_unmapped", rdata, 64'hDEAD);
        check("irq_addr_hit", hit, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
